ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the MIPS datapath: owns the PC, drives the word address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register.
- Computes the next PC for four cases: sequential, branch, jump and jr.
- Supports stall and flush, and has a fault trap for misaligned or out-of-range PCs.
- Sits between the hazard/branch logic in ID and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- IM_WORDS_LOG2, 10, instruction memory depth is 2^IM_WORDS_LOG2 words; the valid PC window is [RESET_PC, RESET_PC + 4*2^IM_WORDS_LOG2).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC and IF/ID.
- flush  in  1  squash the IF/ID contents.
- npc_sel  in  2  next-PC source: 00 = PC+4, 01 = branch, 10 = jump, 11 = jr.
- br_taken  in  1  branch condition from ID; only meaningful when npc_sel = 01.
- imm16  in  16  branch offset from the ID instruction.
- instr_index  in  26  jump field from the ID instruction.
- jr_target  in  32  register value for jr.
- imem_addr  out  32  byte address to the instruction memory; equals the PC.
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  PC of the registered instruction.
- if_id_pc4  out  32  if_id_pc + 4.
- if_id_valid  out  1  the IF/ID contents are a real instruction.
- fault  out  1  sticky trap indicator.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - PC = RESET_PC; state = BOOT.
  - if_id_instr = 0, if_id_pc = 0, if_id_pc4 = 0, if_id_valid = 0, fault = 0.
- State machine:
  - BOOT: lasts one cycle after rst_n deasserts. The PC is held, IF/ID stays invalid. Next state is RUN. This gives the memory its first fetch cycle.
  - RUN: normal fetching.
  - FAULT: PC frozen; if_id_valid = 0 and if_id_instr = 0 every cycle; fault = 1. Exits only by reset.
- imem_addr = PC, combinational. The memory indexes by PC[IM_WORDS_LOG2+1:2].
- Next-PC computation in RUN. Branch and jump targets are relative to the ID instruction, so they use if_id_pc4:
  - 00: PC + 4.
  - 01 with br_taken = 1: if_id_pc4 + (sign_extend(imm16) << 2).
  - 01 with br_taken = 0: PC + 4.
  - 10: {if_id_pc4[31:28], instr_index, 2'b00}.
  - 11: jr_target.
  - All additions are 32-bit and wrap modulo 2^32. No carry out.
- Delay slot: a redirect does NOT squash the instruction currently being fetched. The delay-slot instruction enters IF/ID normally.
- Each edge in RUN, absent stall, flush and fault:
  - if_id_instr <= imem_rdata; if_id_pc <= PC; if_id_pc4 <= PC + 4; if_id_valid <= 1.
  - PC <= next-PC.
- stall = 1: PC and all IF/ID registers hold. npc_sel is ignored, because ID is stalled and its redirect is not final.
- flush = 1: IF/ID is cleared (instr 0, pc 0, pc4 0, valid 0). The PC still advances to next-PC.
- Priority: reset > fault > stall > flush > normal.
  - stall and flush together: stall wins and IF/ID holds.
- Fault detection, evaluated on the candidate next-PC when it would be loaded:
  - Triggers when next-PC[1:0] != 0, or next-PC falls outside the valid window.
  - On the next edge: state = FAULT, fault = 1, PC is NOT updated (keeps the last legal value) and IF/ID is cleared.
  - A fault candidate under stall is ignored, because the PC is not loaded.
- Sequential fall-through past the last word is itself a fault: PC + 4 lands out of range.
- Reset mid-operation from any state: immediate return to the reset values above, then BOOT.

Test Plan:
- Sequential fetch: reset, memory words 0..3 = 32'h1111_0000 + index, npc_sel = 00.
  - Expected: BOOT for one cycle, then if_id_pc = 0x3000, 0x3004, 0x3008 with the matching instrs and valid = 1.
- Taken branch with delay slot: with if_id_pc4 = 0x3008, npc_sel = 01, br_taken = 1, imm16 = 16'hFFFE.
  - Expected: the next PC after the delay slot is 0x3000; the delay-slot instruction at 0x3008 is captured valid.
  - With br_taken = 0 the PC continues to 0x300C.
- Jump and jr:
  - npc_sel = 10, instr_index = 26'h0000C10 with if_id_pc4[31:28] = 0 → PC = 0x3040.
  - npc_sel = 11, jr_target = 0x3100 → PC = 0x3100.
- Stall and flush:
  - stall = 1 for 3 cycles → PC and IF/ID unchanged.
  - stall and flush together → hold.
  - flush alone → if_id_valid = 0, instr = 0, PC advances by 4.
- Faults:
  - jr_target = 0x3102 → next cycle fault = 1, PC stays at its pre-jr value, if_id_valid = 0 and stays 0.
  - jr_target = 0x4000 → same response.
  - Drop rst_n mid-FAULT → PC = 0x3000, fault = 0, BOOT then RUN.
- Async reset mid-run: assert rst_n = 0 between clock edges.
  - Expected: outputs clear immediately without waiting for an edge.
  - After release, exactly one BOOT cycle precedes the first valid capture.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner, next-PC select, IF/ID capture with stall/flush and a sticky fault trap
module ifu_fetch #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter int          IM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fault
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    localparam logic [32:0] PC_END = {1'b0, RESET_PC} + (33'd4 << IM_WORDS_LOG2);

    state_t      state, state_n;
    logic [31:0] pc, pc4, npc, br_off;
    logic        bad, load, capture, clear;

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};
    assign fault     = (state == FAULT);

    // Candidate next PC; branch and jump targets are relative to the instruction sitting in ID
    always_comb begin
        npc = (npc_sel == 2'b01 && br_taken) ? if_id_pc4 + br_off :
              (npc_sel == 2'b10)             ? {if_id_pc4[31:28], instr_index, 2'b00} :
              (npc_sel == 2'b11)             ? jr_target : pc4;
        bad = (npc[1:0] != 2'b00) || (npc < RESET_PC) || ({1'b0, npc} >= PC_END);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= BOOT;
        else        state <= state_n;

    // Next state and PC / IF/ID update strobes; stall beats flush, a bad target only matters when loaded
    always_comb begin
        state_n = state;
        load    = 1'b0;
        capture = 1'b0;
        clear   = 1'b0;
        case (state)
            BOOT: state_n = RUN;
            RUN:
                if (!stall) begin
                    if (bad) begin
                        state_n = FAULT;
                        clear   = 1'b1;
                    end else begin
                        load    = 1'b1;
                        capture = !flush;
                        clear   = flush;
                    end
                end
            FAULT: clear = 1'b1;
            default: state_n = BOOT;
        endcase
    end

    // Program counter; frozen at the last legal value once a fault is taken
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    pc <= RESET_PC;
        else if (load) pc <= npc;

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || clear) begin
            if_id_instr <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (capture) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
        end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard-driven checks of fetch sequencing, redirects, stall/flush, faults and reset
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] instr_index = 26'd0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc, if_id_pc4;
    logic        if_id_valid, fault;
    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int total = 0;
    int bad = 0;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .npc_sel(npc_sel),
        .br_taken(br_taken), .imm16(imm16), .instr_index(instr_index), .jr_target(jr_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[11:2]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1111_0000 + ((a - 32'h0000_3000) >> 2);
    endfunction

    task automatic push(input logic [31:0] a);
        exp_t x;
        x.pc = a;
        x.instr = word_at(a);
        exp_q.push_back(x);
    endtask

    task automatic cycle(input logic s, input logic f, input logic [1:0] sel, input logic br,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
        stall = s; flush = f; npc_sel = sel; br_taken = br;
        imm16 = imm; instr_index = idx; jr_target = jr;
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 16'd0, 26'd0, 32'd0);
    endtask

    task automatic boot();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        seq();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, fault} !== {32'h3000, 96'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_state addr=%h pc=%h pc4=%h instr=%h v=%b f=%b want addr=3000 rest 0",
                     imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, fault);
        end
    endtask

    task automatic test_sequential();
        boot();
        total++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h3000) begin
            bad++;
            $display("FAIL boot_cycle v=%b addr=%h want v=0 addr=3000", if_id_valid, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            push(32'h3000 + 32'(i * 4));
            seq();
            e = exp_q.pop_front();
            total++;
            if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, e.pc, e.pc + 32'd4, e.instr}) begin
                bad++;
                $display("FAIL seq%0d got v=%b pc=%h pc4=%h instr=%h want pc=%h instr=%h",
                         i, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_branch();
        boot();
        seq();
        seq();
        push(32'h3008);
        cycle(1'b0, 1'b0, 2'b01, 1'b1, 16'hFFFE, 26'd0, 32'd0);
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, e.pc, e.instr, 32'h3000}) begin
            bad++;
            $display("FAIL br_taken got v=%b pc=%h instr=%h addr=%h want pc=%h instr=%h addr=3000",
                     if_id_valid, if_id_pc, if_id_instr, imem_addr, e.pc, e.instr);
        end
        boot();
        seq();
        seq();
        push(32'h3008);
        cycle(1'b0, 1'b0, 2'b01, 1'b0, 16'hFFFE, 26'd0, 32'd0);
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, e.pc, e.instr, 32'h300C}) begin
            bad++;
            $display("FAIL br_not_taken got v=%b pc=%h instr=%h addr=%h want pc=%h addr=300c",
                     if_id_valid, if_id_pc, if_id_instr, imem_addr, e.pc);
        end
    endtask

    task automatic test_jump();
        boot();
        push(32'h3000);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 16'd0, 26'h0000C10, 32'd0);
        e = exp_q.pop_front();
        total++;
        if ({if_id_pc, if_id_instr, imem_addr} !== {e.pc, e.instr, 32'h3040}) begin
            bad++;
            $display("FAIL jump got pc=%h instr=%h addr=%h want pc=%h addr=3040", if_id_pc, if_id_instr, imem_addr, e.pc);
        end
        push(32'h3040);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 16'd0, 26'd0, 32'h3100);
        e = exp_q.pop_front();
        total++;
        if ({if_id_pc, if_id_instr, imem_addr} !== {e.pc, e.instr, 32'h3100}) begin
            bad++;
            $display("FAIL jr got pc=%h instr=%h addr=%h want pc=%h instr=%h addr=3100",
                     if_id_pc, if_id_instr, imem_addr, e.pc, e.instr);
        end
        push(32'h3100);
        seq();
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, e.pc, e.instr}) begin
            bad++;
            $display("FAIL jr_fetch got v=%b pc=%h instr=%h want pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_stall_flush();
        boot();
        push(32'h3000);
        seq();
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 3, 2'b11, 1'b0, 16'd0, 26'd0, 32'h3102);
            total++;
            if ({if_id_valid, if_id_pc, if_id_instr, imem_addr, fault} !== {1'b1, e.pc, e.instr, 32'h3004, 1'b0}) begin
                bad++;
                $display("FAIL stall%0d got v=%b pc=%h instr=%h addr=%h f=%b want pc=%h addr=3004 f=0",
                         i, if_id_valid, if_id_pc, if_id_instr, imem_addr, fault, e.pc);
            end
        end
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 16'd0, 26'd0, 32'd0);
        total++;
        if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr, imem_addr} !== {1'b0, 96'd0, 32'h3008}) begin
            bad++;
            $display("FAIL flush got v=%b pc=%h pc4=%h instr=%h addr=%h want all 0 addr=3008",
                     if_id_valid, if_id_pc, if_id_pc4, if_id_instr, imem_addr);
        end
        push(32'h3008);
        seq();
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, e.pc, e.instr}) begin
            bad++;
            $display("FAIL after_flush got v=%b pc=%h instr=%h want pc=%h", if_id_valid, if_id_pc, if_id_instr, e.pc);
        end
    endtask

    task automatic test_fault();
        boot();
        seq();
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 16'd0, 26'd0, 32'h3102);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({fault, if_id_valid, if_id_instr, imem_addr} !== {2'b10, 32'd0, 32'h3004}) begin
                bad++;
                $display("FAIL misalign%0d got f=%b v=%b instr=%h addr=%h want f=1 v=0 addr=3004",
                         i, fault, if_id_valid, if_id_instr, imem_addr);
            end
            seq();
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({fault, imem_addr} !== {1'b0, 32'h3000}) begin
            bad++;
            $display("FAIL fault_reset got f=%b addr=%h want f=0 addr=3000", fault, imem_addr);
        end
        #2;
        rst_n = 1'b1;
        seq();
        total++;
        if (if_id_valid !== 1'b0) begin
            bad++;
            $display("FAIL fault_boot got v=%b want 0", if_id_valid);
        end
        push(32'h3000);
        seq();
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, fault} !== {1'b1, e.pc, e.instr, 1'b0}) begin
            bad++;
            $display("FAIL fault_recover got v=%b pc=%h instr=%h f=%b want pc=%h", if_id_valid, if_id_pc, if_id_instr, fault, e.pc);
        end
        boot();
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 16'd0, 26'd0, 32'h4000);
        total++;
        if ({fault, if_id_valid, imem_addr} !== {2'b10, 32'h3000}) begin
            bad++;
            $display("FAIL range_hi got f=%b v=%b addr=%h want f=1 v=0 addr=3000", fault, if_id_valid, imem_addr);
        end
        boot();
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 16'd0, 26'd0, 32'h2FFC);
        total++;
        if ({fault, imem_addr} !== {1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL range_lo got f=%b addr=%h want f=1 addr=3000", fault, imem_addr);
        end
        boot();
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 16'd0, 26'd0, 32'h3FFC);
        total++;
        if ({fault, imem_addr} !== {1'b0, 32'h3FFC}) begin
            bad++;
            $display("FAIL last_word got f=%b addr=%h want f=0 addr=3ffc", fault, imem_addr);
        end
        seq();
        total++;
        if ({fault, if_id_valid, imem_addr} !== {2'b10, 32'h3FFC}) begin
            bad++;
            $display("FAIL fall_through got f=%b v=%b addr=%h want f=1 v=0 addr=3ffc", fault, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        boot();
        seq();
        seq();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b0, 64'd0, 32'h3000}) begin
            bad++;
            $display("FAIL async_clear got v=%b pc=%h instr=%h addr=%h want 0 addr=3000",
                     if_id_valid, if_id_pc, if_id_instr, imem_addr);
        end
        rst_n = 1'b1;
        seq();
        total++;
        if ({if_id_valid, imem_addr} !== {1'b0, 32'h3000}) begin
            bad++;
            $display("FAIL async_boot got v=%b addr=%h want v=0 addr=3000", if_id_valid, imem_addr);
        end
        push(32'h3000);
        seq();
        e = exp_q.pop_front();
        total++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, e.pc, e.instr}) begin
            bad++;
            $display("FAIL async_first got v=%b pc=%h instr=%h want pc=%h", if_id_valid, if_id_pc, if_id_instr, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1111_0000 + 32'(i);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_flush();
        test_fault();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
